// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker
//   Receive-side monitor for an 8-bit wrapping counter bus. Locks onto the
//   +1 sequence (MAX_VAL wraps to 0), pulses seq_err on every break while
//   locked, keeps a saturating error count and pulses wrap on each
//   MAX_VAL -> 0 step seen while locked.
//
//   Optional feature, macro CHK_PERIOD_EN: measures clk cycles between the
//   last two wraps on 'period'. Without the macro, period is tied to 0.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   cnt_in     [7:0] count value from the upstream counter
//   cnt_valid  cnt_in holds a new sample this cycle
//   locked     checker is in the LOCKED state
//   seq_err    one-cycle pulse, mismatch seen while locked
//   wrap       one-cycle pulse, matching MAX_VAL -> 0 step seen while locked
//   err_cnt    [ERR_W-1:0] saturating count of seq_err pulses
//   period     [15:0] clk cycles between the last two wraps
module cnt_seq_checker #(
  parameter int unsigned MAX_VAL    = 254,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cnt_in,
  input  logic             cnt_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      period
);

  localparam logic [7:0] MAX_C    = 8'(MAX_VAL);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state;
  logic [7:0] expected;
  logic [3:0] run_cnt;
  logic [3:0] miss_cnt;
  logic       prev_max;

  logic in_range;
  logic match;
  logic wrap_now;
  logic lose_lock;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return (v == MAX_C) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  assign in_range = (cnt_in <= MAX_C);
  // Out-of-range values never match, even if 'expected' aliases them.
  assign match    = in_range && (cnt_in == expected);
  // A matching 0 only counts as a wrap when the previous sample was MAX_VAL;
  // after an out-of-range 255 the expected value is also 0 but that is no wrap.
  assign wrap_now = cnt_valid && (state == LOCKED) && match &&
                    (cnt_in == 8'd0) && prev_max;
  assign lose_lock = cnt_valid && (state == LOCKED) && !match &&
                     (miss_cnt + 4'd1 == UNLOCK_C);

  // Sample stage: FSM and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      expected <= '0;
      run_cnt  <= '0;
      miss_cnt <= '0;
      prev_max <= 1'b0;
      locked   <= 1'b0;
      seq_err  <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      seq_err <= 1'b0;
      wrap    <= 1'b0;
      if (cnt_valid) begin
        // Always resync to the observed value.
        expected <= nxt(cnt_in);
        prev_max <= (cnt_in == MAX_C);
        case (state)
          SEARCH: begin
            if (in_range) begin
              run_cnt <= '0;
              state   <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (match) begin
              if (run_cnt + 4'd1 == LOCK_C) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                run_cnt <= run_cnt + 4'd1;
              end
            end else begin
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
              wrap     <= wrap_now;
            end else begin
              seq_err <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              if (lose_lock) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

`ifdef CHK_PERIOD_EN
  logic [15:0] cyc_cnt;
  logic        seen_wrap;

  // Wrap period stage: cyc_cnt restarts at 1 on a wrap so that the value
  // captured at the next wrap equals the full cycle distance.
  always_ff @(posedge clk) begin
    if (rst || lose_lock) begin
      cyc_cnt   <= '0;
      period    <= '0;
      seen_wrap <= 1'b0;
    end else if (state == LOCKED) begin
      if (wrap_now) begin
        cyc_cnt   <= 16'd1;
        seen_wrap <= 1'b1;
        if (seen_wrap) period <= cyc_cnt;
      end else if (cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_cnt_seq_checker.sv
module tb_cnt_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cnt_in = '0;
  logic        cnt_valid = 1'b0;
  logic        locked;
  logic        seq_err;
  logic        wrap;
  logic [7:0]  err_cnt;
  logic [15:0] period;

`ifdef CHK_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        l;
    logic        s;
    logic        w;
    logic [7:0]  e;
    logic [15:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;

  cnt_seq_checker #(
    .MAX_VAL(254), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked), .seq_err(seq_err), .wrap(wrap),
    .err_cnt(err_cnt), .period(period)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ep(input int x);
    return PER_EN ? 16'(x) : 16'd0;
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic l, input logic s, input logic w,
                      input logic [7:0] e, input logic [15:0] p);
    exp_t x;
    @(negedge clk);
    rst       = r;
    cnt_valid = v;
    cnt_in    = d;
    x.id = vec_id; x.l = l; x.s = s; x.w = w; x.e = e; x.p = p;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if (locked !== x.l || seq_err !== x.s || wrap !== x.w ||
            err_cnt !== x.e || period !== x.p) begin
          bad++;
          $display("FAIL vec%0d: got locked=%0b seq_err=%0b wrap=%0b err_cnt=%0d period=%0d, want locked=%0b seq_err=%0b wrap=%0b err_cnt=%0d period=%0d",
                   x.id, locked, seq_err, wrap, err_cnt, period,
                   x.l, x.s, x.w, x.e, x.p);
        end
      end
    end
  end

  initial begin
    // Reset state
    step(1, 0, 8'd0, 0, 0, 0, 0, 0);
    step(1, 1, 8'd7, 0, 0, 0, 0, 0);

    // Lock-in: locked rises after the sample of value 4
    for (int i = 0; i < 10; i++)
      step(0, 1, 8'(i), (i >= 4), 0, 0, 0, 0);

    // Single corrupted sample gives two errors, lock held
    step(0, 1, 8'd10, 1, 0, 0, 0, 0);
    step(0, 1, 8'd11, 1, 0, 0, 0, 0);
    step(0, 1, 8'd99, 1, 1, 0, 1, 0);
    step(0, 1, 8'd13, 1, 1, 0, 2, 0);
    step(0, 1, 8'd14, 1, 0, 0, 2, 0);
    // Idle cycle: state holds, pulses low
    step(0, 0, 8'd77, 1, 0, 0, 2, 0);

    // Run up to MAX_VAL and wrap
    for (int v = 15; v <= 254; v++)
      step(0, 1, 8'(v), 1, 0, 0, 2, 0);
    step(0, 1, 8'd0, 1, 0, 1, 2, 0);
    step(0, 1, 8'd1, 1, 0, 0, 2, 0);
    step(0, 1, 8'd2, 1, 0, 0, 2, 0);

    // Three out-of-range samples drop lock on the third
    step(0, 1, 8'd255, 1, 1, 0, 3, 0);
    step(0, 1, 8'd255, 1, 1, 0, 4, 0);
    step(0, 1, 8'd255, 0, 1, 0, 5, 0);
    // Five correct increments re-lock
    step(0, 1, 8'd5, 0, 0, 0, 5, 0);
    step(0, 1, 8'd6, 0, 0, 0, 5, 0);
    step(0, 1, 8'd7, 0, 0, 0, 5, 0);
    step(0, 1, 8'd8, 0, 0, 0, 5, 0);
    step(0, 1, 8'd9, 1, 0, 0, 5, 0);

    // Reset while locked with err_cnt=5; the sample held during rst is ignored
    step(1, 1, 8'd10, 0, 0, 0, 0, 0);
    step(0, 1, 8'd11, 0, 0, 0, 0, 0);
    step(0, 1, 8'd12, 0, 0, 0, 0, 0);
    step(0, 1, 8'd13, 0, 0, 0, 0, 0);
    step(0, 1, 8'd14, 0, 0, 0, 0, 0);
    step(0, 1, 8'd15, 1, 0, 0, 0, 0);
    step(0, 1, 8'd16, 1, 0, 0, 0, 0);
    // A mismatching 0 is an error, not a wrap
    step(0, 1, 8'd0, 1, 1, 0, 1, 0);
    step(0, 1, 8'd1, 1, 0, 0, 1, 0);

    // Wrap period: first wrap only restarts the counter
    for (int v = 2; v <= 254; v++)
      step(0, 1, 8'(v), 1, 0, 0, 1, 0);
    step(0, 1, 8'd0, 1, 0, 1, 1, 0);
    // Continuous valid: 255 cycles per lap
    for (int v = 1; v <= 254; v++)
      step(0, 1, 8'(v), 1, 0, 0, 1, 0);
    step(0, 1, 8'd0, 1, 0, 1, 1, ep(255));
    // Valid every other cycle: 510 cycles per lap
    for (int v = 1; v <= 254; v++) begin
      step(0, 0, 8'd0, 1, 0, 0, 1, ep(255));
      step(0, 1, 8'(v), 1, 0, 0, 1, ep(255));
    end
    step(0, 0, 8'd0, 1, 0, 0, 1, ep(255));
    step(0, 1, 8'd0, 1, 0, 1, 1, ep(510));
    step(0, 0, 8'd0, 1, 0, 0, 1, ep(510));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_checker.md
Name: cnt_seq_checker

Overview:
Receive-side monitor for an 8-bit wrapping counter bus driven by an upstream counter block.
- Samples the count value, locks onto the +1 sequence, flags every sequence break and counts errors.
- Reports each wrap event.
- Sits at the far end of the counter bus in the test/debug path; its outputs drive status pins.

Parameters:
MAX_VAL, 254, largest legal count value; expected successor of MAX_VAL is 0
LOCK_CNT, 4, consecutive correct increments required to declare lock (1..15)
UNLOCK_CNT, 3, consecutive mismatches while locked that force loss of lock (1..15)
ERR_W, 8, width of error counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
cnt_in  input  8  count value from upstream counter
cnt_valid  input  1  cnt_in is a new sample this cycle; ignored when low
locked  output  1  checker is in LOCKED state
seq_err  output  1  one-cycle pulse: mismatch detected while LOCKED
wrap  output  1  one-cycle pulse: MAX_VAL -> 0 transition observed while LOCKED
err_cnt  output  ERR_W  saturating count of seq_err pulses since reset
period  output  16  clk cycles between the last two wraps (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high, on clk rising edge; it dominates all other inputs, including mid-operation.
  - Outputs after reset: locked=0, seq_err=0, wrap=0, err_cnt=0, period=0.
  - Internal state after reset: state=SEARCH, expected value=0, run counters=0.
- Sampling: action only on cycles with cnt_valid=1; otherwise all state holds and pulses drop to 0.
- Successor function: nxt(v) = (v==MAX_VAL) ? 0 : v+1.
- Match rule: cnt_in == expected. Any cnt_in > MAX_VAL is always a mismatch.
- On every valid sample, expected <= nxt(cnt_in). The checker resyncs to the observed value, so a single corrupted sample yields two mismatches.
- FSM states:
  - SEARCH: first valid sample loads expected, run counter=0, go ACQUIRE. Exception: an out-of-range sample stays in SEARCH.
  - ACQUIRE: match increments run counter. On reaching LOCK_CNT, go LOCKED (locked=1 from the following cycle). Mismatch clears run counter and stays in ACQUIRE. No seq_err or err_cnt activity in this state.
  - LOCKED: match clears miss counter. Mismatch pulses seq_err (registered, asserted the cycle after the sample), increments err_cnt (saturating at all-ones, never wraps) and increments the miss counter. When the miss counter reaches UNLOCK_CNT, go SEARCH (locked=0 the following cycle); the UNLOCK_CNT-th mismatch still pulses seq_err.
- wrap: pulses the cycle after a matching sample of value 0 whose predecessor was MAX_VAL, while in LOCKED. A mismatching 0 does not pulse wrap.
- Latency: all outputs are registered; one clk from the valid sample to the status update.
- Back-to-back valid samples every cycle are supported with no bubbles.

Optional Feature:
Macro CHK_PERIOD_EN.
- Defined:
  - A 16-bit cycle counter runs while LOCKED.
  - On each wrap pulse, period <= cycles since the previous wrap, then the counter restarts.
  - The first wrap after lock only restarts the counter; period is not updated.
  - Counter saturates at 0xFFFF.
  - Counter and period clear on rst or on loss of lock.
- Undefined: period tied to 0; no counter logic synthesized.

Test Plan:
- Reset then valid every cycle with 0,1,2,...: locked rises one cycle after the 5th sample (value 4); seq_err never pulses; err_cnt=0.
- Locked stream 250..254,0,1 with cnt_valid=1 each cycle: wrap pulses once, one cycle after the 0 sample.
- Locked, inject a single corrupted sample (10,11,99,13,14): seq_err pulses for 99 and for 13; err_cnt=2; locked stays 1.
- Locked, feed 3 consecutive wrong values (out-of-range 255, 255, 255): seq_err pulses 3 times, locked=0 after the 3rd; then 5 correct increments re-lock.
- Assert rst mid-stream while locked with err_cnt=5: next cycle locked=0, err_cnt=0, period=0; valid samples held during rst are ignored.
- CHK_PERIOD_EN defined, continuous valid counting 0..254: period=255 after the second wrap post-lock. With cnt_valid toggling 1/0 each cycle, period=510.
